// File: rtl/hermes_buffered_crossbar.sv
// NPORT x NPORT flit crossbar with a small elastic FIFO on every output link.
// Acks depend only on registered FIFO occupancy, never on the downstream credit.
module hermes_buffered_crossbar #(
    parameter int NPORT     = 5,
    parameter int FLIT_SIZE = 32,
    parameter int OUT_DEPTH = 2,
    parameter int SEL_W     = $clog2(NPORT)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NPORT-1:0]           data_av_i,
    input  logic [NPORT*FLIT_SIZE-1:0] data_i,
    input  logic [NPORT*SEL_W-1:0]     outport_i,
    input  logic [NPORT-1:0]           free_i,
    input  logic [NPORT*SEL_W-1:0]     inport_i,
    input  logic [NPORT-1:0]           credit_i,
    output logic [NPORT-1:0]           ack_o,
    output logic [NPORT-1:0]           tx_o,
    output logic [NPORT*FLIT_SIZE-1:0] data_o,
    output logic [NPORT-1:0]           busy_o
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SEL_W:0]   NPORT_L = (SEL_W + 1)'(NPORT);
    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(OUT_DEPTH);

    logic [SEL_W-1:0]     w_outport [NPORT];
    logic [SEL_W-1:0]     w_inport  [NPORT];
    logic [FLIT_SIZE-1:0] w_data_in [NPORT];
    logic [NPORT-1:0]     w_enq;
    logic [NPORT-1:0]     w_deq;
    logic [NPORT-1:0]     w_ack;

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
        assign w_outport[gi] = outport_i[gi*SEL_W +: SEL_W];
        assign w_inport[gi]  = inport_i[gi*SEL_W +: SEL_W];
        assign w_data_in[gi] = data_i[gi*FLIT_SIZE +: FLIT_SIZE];
    end

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_out
        logic [SEL_W-1:0]     w_src;
        logic                 w_conn;
        logic                 w_tx;
        logic [CNT_W-1:0]     r_count;
        logic [PTR_W-1:0]     r_wr_ptr;
        logic [PTR_W-1:0]     r_rd_ptr;
        logic [FLIT_SIZE-1:0] r_mem [OUT_DEPTH];

        assign w_src  = w_inport[gi];
        assign w_conn = !free_i[gi] && ({1'b0, w_src} < NPORT_L);
        assign w_tx   = (r_count != '0);

        // Full test uses the registered count: a same-cycle dequeue does not open a slot.
        assign w_enq[gi] = rst_ni && w_conn && data_av_i[w_src]
                           && (w_outport[w_src] == SEL_W'(gi)) && (r_count < DEPTH_L);
        assign w_deq[gi] = w_tx && credit_i[gi];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                case ({w_enq[gi], w_deq[gi]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_enq[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_deq[gi]) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_enq[gi]) r_mem[r_wr_ptr] <= w_data_in[w_src];
        end

        assign tx_o[gi]   = w_tx;
        assign busy_o[gi] = w_tx;
        assign data_o[gi*FLIT_SIZE +: FLIT_SIZE] = w_tx ? r_mem[r_rd_ptr] : '0;
    end

    // Each output grants exactly one source, so an input is acked by at most one output.
    always_comb begin
        w_ack = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (w_enq[o] && (w_inport[o] == SEL_W'(i)) && (w_outport[i] == SEL_W'(o)))
                    w_ack[i] = 1'b1;
            end
        end
    end

    assign ack_o = w_ack;

endmodule
